// File: rtl/mips_pkg.sv
// Shared mul/div definitions: operation encodings, FSM states and default width.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the mul/div datapath: shift-add multiply step or restoring divide step.
module muldiv_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        trial   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = trial - {1'b0, opnd_i};
        acc_o   = acc_i;
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with MTHI/MTLO write port.
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned DW = 2 * WIDTH;

    md_state_e         state_q;
    logic [CW-1:0]     count_q;
    logic [DW-1:0]     acc_q;
    logic [DW-1:0]     acc_d;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH-1:0]  rs_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              is_div_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              div_zero_q;
    logic              busy_q;
    logic              done_q;

    logic              op_signed;
    logic [WIDTH-1:0]  a_abs;
    logic [WIDTH-1:0]  b_abs;
    logic [DW-1:0]     prod;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  res_hi;
    logic [WIDTH-1:0]  res_lo;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_d)
    );

    // Operand magnitudes for issue; signed ops iterate on absolute values.
    always_comb begin
        op_signed = md_is_signed(op);
        a_abs     = (op_signed && rs_val[WIDTH-1]) ? WIDTH'(0) - rs_val : rs_val;
        b_abs     = (op_signed && rt_val[WIDTH-1]) ? WIDTH'(0) - rt_val : rt_val;
    end

    // Sign correction and special cases applied in FIX.
    always_comb begin
        prod   = neg_res_q ? DW'(0) - acc_q : acc_q;
        quo    = neg_res_q ? WIDTH'(0) - acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem    = neg_rem_q ? WIDTH'(0) - acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
        res_hi = prod[DW-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                res_hi = rs_q;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rs_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= mt_data;
                    if (mtlo) lo_q <= mt_data;
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        count_q    <= '0;
                        is_div_q   <= op[1];
                        neg_res_q  <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_rem_q  <= op_signed && rs_val[WIDTH-1];
                        div_zero_q <= (rt_val == '0);
                        rs_q       <= rs_val;
                        opnd_q     <= b_abs;
                        acc_q      <= {WIDTH'(0), a_abs};
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomized and directed bench for hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .mt_data (mt_data),
        .busy    (busy),
        .done    (done),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO produced by an op, straight from the arithmetic definition.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        logic [31:0]     q, r;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            OP_MULTU: begin
                up = longint'({32'b0, a}) * longint'({32'b0, b});
                return up;
            end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = a / b;
                r = a % b;
                return {r, q};
            end
        endcase
    endfunction

    // Drive a start at the next negedge; returns after the accepting edge E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    // Wait for done with a bound; inj_k>0 pulses ignored start+mthi at that cycle.
    task automatic wait_done(input string tag, input logic [63:0] exp, input int inj_k);
        int k;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = i;
                break;
            end
            if (i == 1 || i == 32) begin
                check_eq({tag, "_hold_hi"}, 64'(HI), 64'(m_hi));
                check_eq({tag, "_hold_lo"}, 64'(LO), 64'(m_lo));
                check_eq({tag, "_busy_run"}, 64'(busy), 64'd1);
            end
            if (i == inj_k) begin
                start   = 1'b1;
                op      = OP_DIVU;
                rs_val  = 32'd99;
                rt_val  = 32'd3;
                mthi    = 1'b1;
                mt_data = 32'h0000_DEAD;
            end else if (i == inj_k + 1) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
        end
        check_eq({tag, "_latency"}, 64'(k), 64'd33);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check_eq({tag, "_hi"}, 64'(HI), 64'(m_hi));
        check_eq({tag, "_lo"}, 64'(LO), 64'(m_lo));
        check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b);
        wait_done(tag, ref_md(o, a, b), 0);
    endtask

    task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] d);
        @(negedge clk);
        mthi    = hi_en;
        mtlo    = lo_en;
        mt_data = d;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (hi_en) m_hi = d;
        if (lo_en) m_lo = d;
        check_eq("mt_hi", 64'(HI), 64'(m_hi));
        check_eq("mt_lo", 64'(LO), 64'(m_lo));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; mt_data = '0;
        m_hi = '0; m_lo = '0;
        #12;
        check_eq("rst_hi", 64'(HI), 64'd0);
        check_eq("rst_lo", 64'(LO), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        check_eq("mult_neg_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFA);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("multu_max_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFE);
        run_op("mult_m1m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_m7_2_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2);
        run_op("div_by0", OP_DIV, 32'h0000_1234, 32'd0);
        check_eq("div_by0_hi_const", 64'(HI), 64'h0000_0000_0000_1234);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by0", OP_DIVU, 32'hCAFE_0001, 32'd0);

        // Start and MTHI while busy are both ignored.
        issue(OP_MULTU, 32'd5, 32'd6);
        wait_done("busy_ignore", 64'd30, 5);
        check_eq("busy_ignore_lo_const", 64'(LO), 64'd30);
        mt_write(1'b0, 1'b1, 32'h0000_BEEF);
        mt_write(1'b1, 1'b1, 32'h1357_9BDF);

        // MT write together with start lands now; result overwrites at completion.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; rs_val = 32'd50; rt_val = 32'd8;
        mthi = 1'b1; mt_data = 32'hA5A5_0000;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0;
        m_hi = 32'hA5A5_0000;
        check_eq("mt_with_start_hi", 64'(HI), 64'(m_hi));
        wait_done("mt_with_start", ref_md(OP_DIVU, 32'd50, 32'd8), 0);

        // Reset mid-operation aborts asynchronously.
        issue(OP_DIV, 32'h0001_0000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_hi", 64'(HI), 64'd0);
        check_eq("abort_lo", 64'(LO), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        run_op("after_abort", OP_DIVU, 32'd100, 32'd7);

        // Random ops interleaved with random MT writes.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op("rand", ro, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
